// File: rtl/kf8253_bus_pkg.sv
// Shared types and constants for the KF8253 peripheral bus initiator.
// Phase counter width is derived from the longest programmable phase.
package kf8253_bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        RECOVER
    } state_t;

    localparam logic [1:0] ADDR_COUNTER_0 = 2'd0;
    localparam logic [1:0] ADDR_COUNTER_1 = 2'd1;
    localparam logic [1:0] ADDR_COUNTER_2 = 2'd2;
    localparam logic [1:0] ADDR_CONTROL   = 2'd3;

    // The counter is loaded with (cycles - 1), so it never holds max_cycles.
    function automatic int cycle_width(input int max_cycles);
        return (max_cycles <= 1) ? 1 : $clog2(max_cycles);
    endfunction

endpackage

// File: rtl/kf8253_bus_initiator_if.sv
// Request/response handshake and KF8253 bus signals of the initiator.
// master: the initiator itself; slave: the host and target around it.
interface kf8253_bus_initiator_if;

    logic       req_valid;
    logic       req_ready;
    logic       req_write;
    logic [1:0] req_address;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       busy;
    logic       chip_select_n;
    logic       read_enable_n;
    logic       write_enable_n;
    logic [1:0] address;
    logic [7:0] data_bus_out;
    logic       data_bus_oe;
    logic [7:0] data_bus_in;

    modport master (
        input  req_valid, req_write, req_address, req_wdata, data_bus_in,
        output req_ready, rsp_valid, rsp_rdata, busy,
        output chip_select_n, read_enable_n, write_enable_n,
        output address, data_bus_out, data_bus_oe
    );

    modport slave (
        output req_valid, req_write, req_address, req_wdata, data_bus_in,
        input  req_ready, rsp_valid, rsp_rdata, busy,
        input  chip_select_n, read_enable_n, write_enable_n,
        input  address, data_bus_out, data_bus_oe
    );

endinterface

// File: rtl/kf8253_phase_timer.sv
// Loadable down-counter with terminal-count flag, shared by all bus phases.
module kf8253_phase_timer #(
    parameter int WIDTH = 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             done
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/kf8253_bus_initiator.sv
// Host-side initiator: turns single-beat requests into timed 8253 I/O cycles.
// Every bus output is a flop loaded from the next-state decode.
module kf8253_bus_initiator
    import kf8253_bus_pkg::*;
#(
    parameter int SETUP_CYCLES    = 1,
    parameter int STROBE_CYCLES   = 2,
    parameter int HOLD_CYCLES     = 1,
    parameter int RECOVERY_CYCLES = 1
) (
    input logic                    clock,
    input logic                    reset_n,
    kf8253_bus_initiator_if.master bus
);

    localparam int MAX_SS = (SETUP_CYCLES > STROBE_CYCLES) ?
                            SETUP_CYCLES : STROBE_CYCLES;
    localparam int MAX_HR = (HOLD_CYCLES > RECOVERY_CYCLES) ?
                            HOLD_CYCLES : RECOVERY_CYCLES;
    localparam int MAX_CYCLES = (MAX_SS > MAX_HR) ? MAX_SS : MAX_HR;
    localparam int CW = cycle_width(MAX_CYCLES);

    localparam logic [CW-1:0] LOAD_SETUP   = CW'(SETUP_CYCLES - 1);
    localparam logic [CW-1:0] LOAD_STROBE  = CW'(STROBE_CYCLES - 1);
    localparam logic [CW-1:0] LOAD_HOLD    = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] LOAD_RECOVER = CW'(RECOVERY_CYCLES - 1);

    state_t          state;
    state_t          state_n;
    logic            accept;
    logic            load;
    logic [CW-1:0]   load_value;
    logic            timer_done;
    logic            write_next;
    logic            cycle_active;
    logic            strobe_active;
    logic            capture;
    logic            finish;

    logic            write_q;
    logic            cs_n_q;
    logic            rd_n_q;
    logic            wr_n_q;
    logic            oe_q;
    logic            rsp_valid_q;
    logic            busy_q;
    logic [1:0]      addr_q;
    logic [7:0]      dout_q;
    logic [7:0]      rdata_q;

    kf8253_phase_timer #(
        .WIDTH(CW)
    ) u_phase_timer (
        .clock     (clock),
        .reset_n   (reset_n),
        .load      (load),
        .load_value(load_value),
        .done      (timer_done)
    );

    assign accept     = bus.req_valid && (state == IDLE);
    assign write_next = accept ? bus.req_write : write_q;

    always_comb begin
        state_n    = state;
        load       = 1'b0;
        load_value = '0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_n    = SETUP;
                    load       = 1'b1;
                    load_value = LOAD_SETUP;
                end
            end
            SETUP: begin
                if (timer_done) begin
                    state_n    = STROBE;
                    load       = 1'b1;
                    load_value = LOAD_STROBE;
                end
            end
            STROBE: begin
                if (timer_done) begin
                    state_n    = HOLD;
                    load       = 1'b1;
                    load_value = LOAD_HOLD;
                end
            end
            HOLD: begin
                if (timer_done) begin
                    state_n    = RECOVER;
                    load       = 1'b1;
                    load_value = LOAD_RECOVER;
                end
            end
            RECOVER: begin
                if (timer_done) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign cycle_active  = (state_n == SETUP) || (state_n == STROBE) ||
                           (state_n == HOLD);
    assign strobe_active = (state_n == STROBE);
    // Read data is sampled on the edge that ends the last strobe cycle.
    assign capture       = (state == STROBE) && timer_done && !write_q;
    assign finish        = (state == HOLD) && timer_done;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            write_q     <= 1'b0;
            addr_q      <= '0;
            dout_q      <= '0;
            cs_n_q      <= 1'b1;
            rd_n_q      <= 1'b1;
            wr_n_q      <= 1'b1;
            oe_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
            busy_q      <= 1'b0;
        end else begin
            if (accept) begin
                write_q <= bus.req_write;
                addr_q  <= bus.req_address;
                if (bus.req_write) begin
                    dout_q <= bus.req_wdata;
                end
            end
            cs_n_q      <= !cycle_active;
            rd_n_q      <= !(strobe_active && !write_next);
            wr_n_q      <= !(strobe_active && write_next);
            oe_q        <= cycle_active && write_next;
            rsp_valid_q <= finish;
            busy_q      <= (state_n != IDLE);
            if (capture) begin
                rdata_q <= bus.data_bus_in;
            end
        end
    end

    assign bus.req_ready      = (state == IDLE);
    assign bus.rsp_valid      = rsp_valid_q;
    assign bus.rsp_rdata      = rdata_q;
    assign bus.busy           = busy_q;
    assign bus.chip_select_n  = cs_n_q;
    assign bus.read_enable_n  = rd_n_q;
    assign bus.write_enable_n = wr_n_q;
    assign bus.address        = addr_q;
    assign bus.data_bus_out   = dout_q;
    assign bus.data_bus_oe    = oe_q;

endmodule

// File: tb/tb_kf8253_bus_initiator.sv
// Bench for kf8253_bus_initiator: default and stretched-timing instances
// compared cycle by cycle against a phase-window model of the bus cycle.
module tb_kf8253_bus_initiator;
    import kf8253_bus_pkg::*;

    typedef struct packed {
        logic       cs_n;
        logic       rd_n;
        logic       wr_n;
        logic       oe;
        logic       rv;
        logic       rdy;
        logic       bs;
        logic [1:0] a;
        logic [7:0] d;
        logic [7:0] rdata;
    } obs_t;

    logic clock = 1'b0;
    logic rst0_n;
    logic rst1_n;

    int checks   = 0;
    int failures = 0;

    obs_t       trace [64];
    logic [7:0] last_rd [2];
    obs_t       prev [2];

    kf8253_bus_initiator_if bus0 ();
    kf8253_bus_initiator_if bus1 ();

    kf8253_bus_initiator dut0 (
        .clock  (clock),
        .reset_n(rst0_n),
        .bus    (bus0)
    );

    kf8253_bus_initiator #(
        .SETUP_CYCLES   (3),
        .STROBE_CYCLES  (4),
        .HOLD_CYCLES    (2),
        .RECOVERY_CYCLES(2)
    ) dut1 (
        .clock  (clock),
        .reset_n(rst1_n),
        .bus    (bus1)
    );

    always #5 clock = ~clock;

    function automatic int ps(int dut); return (dut == 0) ? 1 : 3; endfunction
    function automatic int pt(int dut); return (dut == 0) ? 2 : 4; endfunction
    function automatic int ph(int dut); return (dut == 0) ? 1 : 2; endfunction
    function automatic int pr(int dut); return (dut == 0) ? 1 : 2; endfunction

    function automatic obs_t sample(int dut);
        obs_t o;
        if (dut == 0) begin
            o.cs_n  = bus0.chip_select_n;
            o.rd_n  = bus0.read_enable_n;
            o.wr_n  = bus0.write_enable_n;
            o.oe    = bus0.data_bus_oe;
            o.rv    = bus0.rsp_valid;
            o.rdy   = bus0.req_ready;
            o.bs    = bus0.busy;
            o.a     = bus0.address;
            o.d     = bus0.data_bus_out;
            o.rdata = bus0.rsp_rdata;
        end else begin
            o.cs_n  = bus1.chip_select_n;
            o.rd_n  = bus1.read_enable_n;
            o.wr_n  = bus1.write_enable_n;
            o.oe    = bus1.data_bus_oe;
            o.rv    = bus1.rsp_valid;
            o.rdy   = bus1.req_ready;
            o.bs    = bus1.busy;
            o.a     = bus1.address;
            o.d     = bus1.data_bus_out;
            o.rdata = bus1.rsp_rdata;
        end
        return o;
    endfunction

    // Expected bus state k cycles after the acceptance edge.
    function automatic obs_t model(int dut, int k, logic w, logic [1:0] a,
                                   logic [7:0] d, logic [7:0] old_rd,
                                   logic [7:0] new_rd);
        obs_t e;
        int s, t, h, tot;
        s   = ps(dut);
        t   = pt(dut);
        h   = ph(dut);
        tot = 1 + s + t + h + pr(dut);
        e.cs_n  = !(k >= 1 && k <= s + t + h);
        e.rd_n  = !(!w && k > s && k <= s + t);
        e.wr_n  = !(w && k > s && k <= s + t);
        e.oe    = w && k >= 1 && k <= s + t + h;
        e.rv    = (k == s + t + h + 1);
        e.rdy   = (k == tot);
        e.bs    = (k < tot);
        e.a     = a;
        e.d     = d;
        e.rdata = (!w && k > s + t) ? new_rd : old_rd;
        return e;
    endfunction

    function automatic obs_t mask(logic w);
        obs_t m;
        m = '1;
        if (!w) m.d = '0;
        return m;
    endfunction

    function automatic obs_t reset_obs();
        obs_t r;
        r       = '0;
        r.cs_n  = 1'b1;
        r.rd_n  = 1'b1;
        r.wr_n  = 1'b1;
        r.rdy   = 1'b1;
        return r;
    endfunction

    task automatic set_req(int dut, logic v, logic w, logic [1:0] a,
                           logic [7:0] d);
        if (dut == 0) begin
            bus0.req_valid = v; bus0.req_write = w;
            bus0.req_address = a; bus0.req_wdata = d;
        end else begin
            bus1.req_valid = v; bus1.req_write = w;
            bus1.req_address = a; bus1.req_wdata = d;
        end
    endtask

    task automatic set_din(int dut, logic [7:0] v);
        if (dut == 0) bus0.data_bus_in = v;
        else bus1.data_bus_in = v;
    endtask

    // Issues one request and records the bus every cycle into trace[1..tot].
    task automatic run_txn(int dut, logic w, logic [1:0] a, logic [7:0] d,
                           logic [7:0] rdval, bit noise, output int tot);
        obs_t o;
        int st, waited;
        st  = ps(dut) + pt(dut);
        tot = 1 + st + ph(dut) + pr(dut);
        @(negedge clock);
        o = sample(dut);
        waited = 0;
        while (!o.rdy && waited < 50) begin
            @(negedge clock);
            o = sample(dut);
            waited++;
        end
        if (!o.rdy) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout dut%0d got=0 exp=1", dut);
        end
        set_req(dut, 1'b1, w, a, d);
        set_din(dut, 8'hFF);
        for (int k = 1; k <= tot; k++) begin
            @(negedge clock);
            trace[k] = sample(dut);
            if (noise && k < tot)
                set_req(dut, 1'($urandom), 1'($urandom), 2'($urandom),
                        8'($urandom));
            else
                set_req(dut, 1'b0, w, a, d);
            if (k == st) set_din(dut, rdval);
            else if (k > ps(dut) && k < st) set_din(dut, ~rdval);
            else set_din(dut, 8'hFF);
        end
    endtask

    // Bus protocol invariants on both instances, every cycle.
    always @(negedge clock) begin
        for (int i = 0; i < 2; i++) begin
            obs_t o;
            o = sample(i);
            checks++;
            if ((!o.rd_n && !o.wr_n) ||
                ((!o.rd_n || !o.wr_n) && o.cs_n) ||
                (!o.cs_n && !prev[i].cs_n &&
                 (o.a !== prev[i].a || (o.oe && o.d !== prev[i].d)))) begin
                failures++;
                $display("FAIL invariant dut%0d got=%h prev=%h", i, o, prev[i]);
            end
            prev[i] = o;
        end
    end

    task automatic test_reset();
        obs_t o;
        @(negedge clock);
        for (int i = 0; i < 2; i++) begin
            o = sample(i);
            checks++;
            if (o !== reset_obs()) begin
                failures++;
                $display("FAIL reset dut%0d got=%h exp=%h", i, o, reset_obs());
            end
        end
    endtask

    task automatic test_write_default();
        obs_t e;
        int tot;
        run_txn(0, 1'b1, ADDR_CONTROL, 8'h34, 8'h00, 1'b0, tot);
        for (int k = 1; k <= tot; k++) begin
            e = model(0, k, 1'b1, ADDR_CONTROL, 8'h34, last_rd[0], last_rd[0]);
            checks++;
            if (((trace[k] ^ e) & mask(1'b1)) !== '0) begin
                failures++;
                $display("FAIL write_default k=%0d got=%h exp=%h", k, trace[k], e);
            end
        end
    endtask

    task automatic test_read_default();
        obs_t e;
        int tot;
        run_txn(0, 1'b0, ADDR_COUNTER_0, 8'h00, 8'hA5, 1'b0, tot);
        for (int k = 1; k <= tot; k++) begin
            e = model(0, k, 1'b0, ADDR_COUNTER_0, 8'h00, last_rd[0], 8'hA5);
            checks++;
            if (((trace[k] ^ e) & mask(1'b0)) !== '0) begin
                failures++;
                $display("FAIL read_default k=%0d got=%h exp=%h", k, trace[k], e);
            end
        end
        last_rd[0] = 8'hA5;
    endtask

    task automatic test_random_ignore(int dut, int n);
        obs_t e;
        int tot;
        logic w;
        logic [1:0] a;
        logic [7:0] d, rv, nr;
        for (int i = 0; i < n; i++) begin
            w  = 1'($urandom);
            a  = 2'($urandom);
            d  = 8'($urandom);
            rv = 8'($urandom);
            nr = w ? last_rd[dut] : rv;
            run_txn(dut, w, a, d, rv, 1'b1, tot);
            for (int k = 1; k <= tot; k++) begin
                e = model(dut, k, w, a, d, last_rd[dut], nr);
                checks++;
                if (((trace[k] ^ e) & mask(w)) !== '0) begin
                    failures++;
                    $display("FAIL random dut%0d txn=%0d k=%0d got=%h exp=%h",
                             dut, i, k, trace[k], e);
                end
            end
            last_rd[dut] = nr;
        end
    endtask

    task automatic test_back_to_back();
        obs_t hist [80];
        int acc [3];
        int idx;
        bit just;
        logic [1:0] aa [3];
        logic [7:0] dd [3];
        for (int i = 0; i < 3; i++) begin
            aa[i] = 2'($urandom);
            dd[i] = 8'($urandom);
            acc[i] = 0;
        end
        idx  = 0;
        just = 1'b0;
        @(negedge clock);
        set_req(0, 1'b1, 1'b1, aa[0], dd[0]);
        for (int c = 0; c < 80; c++) begin
            @(negedge clock);
            hist[c] = sample(0);
            if (just) begin
                just = 1'b0;
                if (idx < 3) set_req(0, 1'b1, 1'b1, aa[idx], dd[idx]);
                else set_req(0, 1'b0, 1'b0, 2'd0, 8'd0);
            end else if (hist[c].rdy && idx < 3) begin
                acc[idx] = c;
                idx++;
                just = 1'b1;
            end
        end
        checks++;
        if (idx !== 3) begin
            failures++;
            $display("FAIL b2b_count got=%0d exp=3", idx);
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (acc[i] + 1 >= 80 || hist[acc[i] + 1].cs_n !== 1'b0 ||
                    hist[acc[i] + 1].oe !== 1'b1 ||
                    hist[acc[i] + 1].a !== aa[i] ||
                    hist[acc[i] + 1].d !== dd[i]) begin
                    failures++;
                    $display("FAIL b2b_data txn=%0d got=%h exp_a=%0d exp_d=%h",
                             i, hist[acc[i] + 1], aa[i], dd[i]);
                end
                if (i > 0) begin
                    checks++;
                    if (acc[i] - acc[i-1] !== 6 || hist[acc[i]].cs_n !== 1'b1) begin
                        failures++;
                        $display("FAIL b2b_spacing txn=%0d got=%0d exp=6 cs_n=%b",
                                 i, acc[i] - acc[i-1], hist[acc[i]].cs_n);
                    end
                end
            end
        end
    endtask

    task automatic test_reset_mid_strobe();
        obs_t o, e, rm;
        int tot;
        rm     = '1;
        rm.rdy = 1'b0;
        @(negedge clock);
        set_req(0, 1'b1, 1'b1, ADDR_COUNTER_1, 8'h5A);
        @(negedge clock);
        set_req(0, 1'b0, 1'b0, 2'd0, 8'd0);
        @(negedge clock);
        o = sample(0);
        checks++;
        if (o.wr_n !== 1'b0 || o.cs_n !== 1'b0) begin
            failures++;
            $display("FAIL pre_reset_strobe got_wr_n=%b got_cs_n=%b exp=0", o.wr_n, o.cs_n);
        end
        #1 rst0_n = 1'b0;
        #1 o = sample(0);
        checks++;
        if (((o ^ reset_obs()) & rm) !== '0) begin
            failures++;
            $display("FAIL async_reset got=%h exp=%h", o, reset_obs());
        end
        repeat (2) begin
            @(negedge clock);
            o = sample(0);
            checks++;
            if (o.rv !== 1'b0 || o.cs_n !== 1'b1) begin
                failures++;
                $display("FAIL reset_hold got_rv=%b got_cs_n=%b exp=0/1", o.rv, o.cs_n);
            end
        end
        rst0_n = 1'b1;
        @(negedge clock);
        o = sample(0);
        checks++;
        if (o !== reset_obs()) begin
            failures++;
            $display("FAIL post_reset got=%h exp=%h", o, reset_obs());
        end
        last_rd[0] = 8'h00;
        run_txn(0, 1'b0, ADDR_COUNTER_2, 8'h00, 8'h3C, 1'b0, tot);
        for (int k = 1; k <= tot; k++) begin
            e = model(0, k, 1'b0, ADDR_COUNTER_2, 8'h00, 8'h00, 8'h3C);
            checks++;
            if (((trace[k] ^ e) & mask(1'b0)) !== '0) begin
                failures++;
                $display("FAIL read_after_reset k=%0d got=%h exp=%h", k, trace[k], e);
            end
        end
        last_rd[0] = 8'h3C;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst0_n = 1'b0;
        rst1_n = 1'b0;
        last_rd[0] = 8'h00;
        last_rd[1] = 8'h00;
        set_req(0, 1'b0, 1'b0, 2'd0, 8'd0);
        set_req(1, 1'b0, 1'b0, 2'd0, 8'd0);
        set_din(0, 8'hFF);
        set_din(1, 8'hFF);
        repeat (3) @(negedge clock);
        rst0_n = 1'b1;
        rst1_n = 1'b1;
        test_reset();
        test_write_default();
        test_read_default();
        test_random_ignore(0, 8);
        test_random_ignore(1, 6);
        test_back_to_back();
        test_reset_mid_strobe();
        repeat (2) @(negedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
